strobe_cmp_reg: RTL

//   Receive-side pin channel of the ASIC tester, the counterpart of the double-buffered drive/format register.

---
 rtl/strobe_cmp_if.sv | 43 ++++
 rtl/strobe_cmp_reg.sv | 128 ++++++++++++
 2 files changed

// File: rtl/strobe_cmp_if.sv
// Bus between the pattern sequencer and one receive-side pin channel.
// The sequencer side drives the programming and control fields; the channel reports compare results.
interface strobe_cmp_if #(
  parameter int EDGE_W = 7,
  parameter int CYC_W  = 8,
  parameter int FCNT_W = 16
);
  logic              EN_CMP_LOGIC;
  logic              DUT_IN;
  logic              LOAD_EXP;
  logic              TRANSFER_EXP;
  logic              EXP;
  logic              LOAD_MASK;
  logic              TRANSFER_MASK;
  logic              MASK;
  logic              MODE;
  logic [EDGE_W-1:0] STROBE_EDGE_1;
  logic [EDGE_W-1:0] STROBE_EDGE_2;
  logic [EDGE_W-1:0] WINDOW_END_1;
  logic [CYC_W-1:0]  CYCLE_LENGTH_1;
  logic              TEST_CYCLE;
  logic              CLR_FAIL;
  logic              CYCLE_START;
  logic              CMP_VALID;
  logic              SAMPLE;
  logic              FAIL;
  logic              FAIL_STICKY;
  logic [FCNT_W-1:0] FAIL_COUNT;

  modport master (
    output EN_CMP_LOGIC, DUT_IN, LOAD_EXP, TRANSFER_EXP, EXP, LOAD_MASK, TRANSFER_MASK,
           MASK, MODE, STROBE_EDGE_1, STROBE_EDGE_2, WINDOW_END_1, CYCLE_LENGTH_1,
           TEST_CYCLE, CLR_FAIL,
    input  CYCLE_START, CMP_VALID, SAMPLE, FAIL, FAIL_STICKY, FAIL_COUNT
  );

  modport slave (
    input  EN_CMP_LOGIC, DUT_IN, LOAD_EXP, TRANSFER_EXP, EXP, LOAD_MASK, TRANSFER_MASK,
           MASK, MODE, STROBE_EDGE_1, STROBE_EDGE_2, WINDOW_END_1, CYCLE_LENGTH_1,
           TEST_CYCLE, CLR_FAIL,
    output CYCLE_START, CMP_VALID, SAMPLE, FAIL, FAIL_STICKY, FAIL_COUNT
  );
endinterface

// File: rtl/strobe_cmp_reg.sv
// Receive-side tester pin channel: synchronises the DUT pin, strobes it per test cycle (edge or window),
// compares against double-buffered expect/mask and keeps sticky and saturating fail statistics.
module strobe_cmp_reg #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_W      = 7,
  parameter int CYC_W       = 8,
  parameter int FCNT_W      = 16
) (
  input logic        CLK,
  input logic        RST,
  strobe_cmp_if.slave bus
);

  localparam int CW = (EDGE_W > CYC_W) ? EDGE_W : CYC_W;
  localparam logic [CYC_W-1:0]  CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

  function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
    return (&v) ? v : v + FCNT_ONE;
  endfunction

  logic [SYNC_STAGES-1:0] din_sync;
  logic                   din_s;
  logic [CYC_W-1:0]       cnt_p0;
  logic                   err_p0;
  logic                   exp_buf, exp_act;
  logic                   mask_buf, mask_act, mode_buf, mode_act;
  logic                   vld_p1, fail_p1, sample_p1, cstart_p1;
  logic                   sticky_q;
  logic [FCNT_W-1:0]      fcnt_q;

  logic                   en;
  logic                   cyc_wrap;
  logic [EDGE_W-1:0]      se_sel;
  logic [CW-1:0]          cnt_x, len_x, se_x, we_x, wend_x;
  logic                   se_ok, at_open, in_win, at_close;
  logic                   mism, err_cur, edge_hit, win_hit, cmp_hit, fail_nxt;

  assign en       = bus.EN_CMP_LOGIC;
  assign din_s    = din_sync[SYNC_STAGES-1];
  assign cyc_wrap = (bus.CYCLE_LENGTH_1 <= CYC_ONE) || (cnt_p0 >= bus.CYCLE_LENGTH_1 - CYC_ONE);

  // Strobe selection and window decode on the common-width counter view
  assign se_sel   = bus.TEST_CYCLE ? bus.STROBE_EDGE_2 : bus.STROBE_EDGE_1;
  assign cnt_x    = CW'(cnt_p0);
  assign len_x    = CW'(bus.CYCLE_LENGTH_1);
  assign se_x     = CW'(se_sel);
  assign we_x     = CW'(bus.WINDOW_END_1);
  assign wend_x   = (we_x < se_x) ? se_x : we_x;
  assign se_ok    = se_x < len_x;
  assign at_open  = en && se_ok && (cnt_x == se_x);
  assign in_win   = en && se_ok && (cnt_x >= se_x) && (cnt_x <= wend_x);
  assign at_close = en && se_ok && (cnt_x == wend_x);

  assign mism     = din_s ^ exp_act;
  assign err_cur  = at_open ? 1'b0 : err_p0;
  assign edge_hit = !mode_act && at_open;
  assign win_hit  = mode_act && at_close;
  assign cmp_hit  = !mask_act && (edge_hit || win_hit);
  assign fail_nxt = cmp_hit && (edge_hit ? mism : (err_cur | mism));

  always_ff @(posedge CLK) begin
    if (RST) din_sync <= '0;
    else     din_sync <= {din_sync[SYNC_STAGES-2:0], bus.DUT_IN};
  end

  // Stage p0: cycle counter, window error accumulator, expect/mask buffers
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_p0   <= '0;
      err_p0   <= 1'b0;
      exp_buf  <= 1'b0;
      exp_act  <= 1'b0;
      mask_buf <= 1'b0;
      mask_act <= 1'b0;
      mode_buf <= 1'b0;
      mode_act <= 1'b0;
    end else begin
      if (!en || cyc_wrap) cnt_p0 <= '0;
      else                 cnt_p0 <= cnt_p0 + CYC_ONE;
      if (mode_act && at_open)     err_p0 <= mism;
      else if (mode_act && in_win) err_p0 <= err_p0 | mism;
      // Transfer reads the buffer before this clock's load lands
      if (bus.TRANSFER_EXP) exp_act <= exp_buf;
      if (bus.LOAD_EXP)     exp_buf <= bus.EXP;
      if (bus.TRANSFER_MASK) begin
        mask_act <= mask_buf;
        mode_act <= mode_buf;
      end
      if (bus.LOAD_MASK) begin
        mask_buf <= bus.MASK;
        mode_buf <= bus.MODE;
      end
    end
  end

  // Stage p1: registered compare result and fail statistics
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1    <= 1'b0;
      fail_p1   <= 1'b0;
      sample_p1 <= 1'b0;
      cstart_p1 <= 1'b0;
      sticky_q  <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      vld_p1    <= cmp_hit;
      fail_p1   <= fail_nxt;
      cstart_p1 <= en && (cnt_p0 == '0);
      if (cmp_hit) sample_p1 <= din_s;
      if (bus.CLR_FAIL) begin
        sticky_q <= fail_nxt;
        fcnt_q   <= fail_nxt ? FCNT_ONE : '0;
      end else if (fail_nxt) begin
        sticky_q <= 1'b1;
        fcnt_q   <= sat_inc(fcnt_q);
      end
    end
  end

  assign bus.CYCLE_START = cstart_p1;
  assign bus.CMP_VALID   = vld_p1;
  assign bus.SAMPLE      = sample_p1;
  assign bus.FAIL        = fail_p1;
  assign bus.FAIL_STICKY = sticky_q;
  assign bus.FAIL_COUNT  = fcnt_q;

endmodule
